// File: rtl/vpu_pkg.sv
// Shared types and helpers for the vector post-processing pipe.
package vpu_pkg;

    typedef enum logic [1:0] {
        BYPASS    = 2'b00,
        FWD       = 2'b01,
        FWD_CACHE = 2'b10,
        BWD       = 2'b11
    } vpu_mode_e;

    localparam int LEAK_FRAC = 8;
    localparam int CALC_W    = 64;

    // Clamp a wide signed value into the signed range of 'width' bits.
    function automatic logic signed [CALC_W-1:0] sat_w(input logic signed [CALC_W-1:0] value,
                                                       input int width);
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage

// File: rtl/vpu_h_fifo.sv
// H-cache FIFO, W bits by DEPTH entries; read data is the combinational head, one-cycle push/pop.
// A push into a full FIFO is dropped unless a pop frees the slot in the same cycle; clear wins.
module vpu_h_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop,
    output logic [W-1:0]                 pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push)
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)
                count_q <= count_q + CW'(1);
            else if (!do_push && do_pop)
                count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/vpu_stream_pipe.sv
// N-lane requant -> bias/sat -> lrelu|lrd|pass pipe, 3 cycles accept-to-valid, 1 vector/cycle.
// Whole pipe freezes while out_valid && !out_ready; BWD beats also wait for a cached H vector.
module vpu_stream_pipe
    import vpu_pkg::*;
#(
    parameter int N       = 4,
    parameter int ACC_W   = 32,
    parameter int DATA_W  = 16,
    parameter int H_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     cfg_mode,
    input  logic [15:0]                    cfg_scale,
    input  logic [4:0]                     cfg_shift,
    input  logic [15:0]                    cfg_zero_point,
    input  logic [15:0]                    cfg_leak,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N*ACC_W-1:0]             in_data,
    input  logic [N-1:0]                   in_mask,
    input  logic [N*DATA_W-1:0]            bias_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N*DATA_W-1:0]            out_data,
    output logic [N-1:0]                   out_mask,
    input  logic                           h_clear,
    output logic [$clog2(H_DEPTH+1)-1:0]   h_count,
    output logic                           h_overflow,
    output logic                           busy
);
    localparam int VW = N * DATA_W;

    vpu_mode_e   in_mode;
    logic        advance;
    logic        in_fire;
    logic        h_push;
    logic        h_pop;
    logic        h_full;
    logic        h_empty;
    logic        h_ovf_q;
    logic [VW-1:0] h_pop_dat;

    logic        s1_vld_q, s2_vld_q, s3_vld_q;
    vpu_mode_e   s1_mode_q, s2_mode_q, s3_mode_q;
    logic [N-1:0]  s1_mask_q, s2_mask_q, s3_mask_q;
    logic [15:0]   s1_leak_q, s2_leak_q;
    logic [VW-1:0] s1_dat_q, s1_bias_q, s1_h_q;
    logic [VW-1:0] s2_dat_q, s2_h_q;
    logic [VW-1:0] s3_dat_q;
    logic [VW-1:0] s1_dat_d, s2_dat_d, s3_dat_d;

    assign in_mode  = vpu_mode_e'(cfg_mode);
    assign advance  = !s3_vld_q || out_ready;
    assign in_ready = advance && !(in_mode == BWD && h_empty);
    assign in_fire  = in_valid && in_ready;
    assign h_pop    = in_fire && (in_mode == BWD);
    assign h_push   = s3_vld_q && out_ready && (s3_mode_q == FWD_CACHE);

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_W-1:0] rq_w;
        logic [DATA_W-1:0] s2_w;
        logic [DATA_W-1:0] s3_w;

        always_comb begin : p_requant
            logic signed [CALC_W-1:0] p;
            p = CALC_W'($signed(in_data[i*ACC_W +: ACC_W]));
            p = p * $signed({{(CALC_W-16){1'b0}}, cfg_scale});
            if (cfg_shift != 5'd0)
                p = (p + (64'sd1 <<< (cfg_shift - 5'd1))) >>> cfg_shift;
            p = p + CALC_W'($signed(cfg_zero_point));
            rq_w = DATA_W'(sat_w(p, DATA_W));
        end

        always_comb begin : p_bias
            logic signed [CALC_W-1:0] x;
            x = CALC_W'($signed(s1_dat_q[i*DATA_W +: DATA_W]))
              + CALC_W'($signed(s1_bias_q[i*DATA_W +: DATA_W]));
            s2_w = s1_dat_q[i*DATA_W +: DATA_W];
            if (s1_mode_q == FWD || s1_mode_q == FWD_CACHE)
                s2_w = DATA_W'(sat_w(x, DATA_W));
        end

        // FWD modes gate on the value's own sign, BWD on the cached H sign.
        always_comb begin : p_act
            logic signed [CALC_W-1:0] x;
            logic signed [CALC_W-1:0] h;
            logic signed [CALC_W-1:0] leaked;
            logic                     neg;
            x      = CALC_W'($signed(s2_dat_q[i*DATA_W +: DATA_W]));
            h      = CALC_W'($signed(s2_h_q[i*DATA_W +: DATA_W]));
            leaked = sat_w((x * CALC_W'($signed(s2_leak_q))) >>> LEAK_FRAC, DATA_W);
            neg    = (s2_mode_q == BWD) ? (h < 0) : (x < 0);
            s3_w   = DATA_W'(x);
            if (s2_mode_q != BYPASS && neg)
                s3_w = DATA_W'(leaked);
            if (!s2_mask_q[i])
                s3_w = '0;
        end

        assign s1_dat_d[i*DATA_W +: DATA_W] = rq_w;
        assign s2_dat_d[i*DATA_W +: DATA_W] = s2_w;
        assign s3_dat_d[i*DATA_W +: DATA_W] = s3_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s3_vld_q  <= 1'b0;
            s1_mode_q <= BYPASS;
            s2_mode_q <= BYPASS;
            s3_mode_q <= BYPASS;
            s1_mask_q <= '0;
            s2_mask_q <= '0;
            s3_mask_q <= '0;
            s1_leak_q <= '0;
            s2_leak_q <= '0;
            s1_dat_q  <= '0;
            s1_bias_q <= '0;
            s1_h_q    <= '0;
            s2_dat_q  <= '0;
            s2_h_q    <= '0;
            s3_dat_q  <= '0;
        end else if (advance) begin
            s1_vld_q  <= in_fire;
            s1_mode_q <= in_mode;
            s1_mask_q <= in_mask;
            s1_leak_q <= cfg_leak;
            s1_dat_q  <= s1_dat_d;
            s1_bias_q <= bias_in;
            s1_h_q    <= h_pop_dat;
            s2_vld_q  <= s1_vld_q;
            s2_mode_q <= s1_mode_q;
            s2_mask_q <= s1_mask_q;
            s2_leak_q <= s1_leak_q;
            s2_dat_q  <= s2_dat_d;
            s2_h_q    <= s1_h_q;
            s3_vld_q  <= s2_vld_q;
            s3_mode_q <= s2_mode_q;
            s3_mask_q <= s2_mask_q;
            s3_dat_q  <= s3_dat_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            h_ovf_q <= 1'b0;
        else if (h_clear)
            h_ovf_q <= 1'b0;
        else if (h_push && h_full && !h_pop)
            h_ovf_q <= 1'b1;
    end

    vpu_h_fifo #(
        .W     (VW),
        .DEPTH (H_DEPTH)
    ) u_h_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (h_clear),
        .push     (h_push),
        .push_dat (s3_dat_q),
        .pop      (h_pop),
        .pop_dat  (h_pop_dat),
        .count    (h_count),
        .full     (h_full),
        .empty    (h_empty)
    );

    assign out_valid  = s3_vld_q;
    assign out_data   = s3_dat_q;
    assign out_mask   = s3_mask_q;
    assign h_overflow = h_ovf_q;
    assign busy       = s1_vld_q || s2_vld_q || s3_vld_q;

endmodule

// File: tb/tb_vpu_stream_pipe.sv
// Scoreboard bench for vpu_stream_pipe: directed corner beats plus randomized traffic and backpressure.
module tb_vpu_stream_pipe;
    localparam int N       = 4;
    localparam int ACC_W   = 32;
    localparam int DATA_W  = 16;
    localparam int H_DEPTH = 4;
    localparam int HW      = $clog2(H_DEPTH + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          cfg_mode;
    logic [15:0]         cfg_scale;
    logic [4:0]          cfg_shift;
    logic [15:0]         cfg_zero_point;
    logic [15:0]         cfg_leak;
    logic                in_valid;
    logic                in_ready;
    logic [N*ACC_W-1:0]  in_data;
    logic [N-1:0]        in_mask;
    logic [N*DATA_W-1:0] bias_in;
    logic                out_valid;
    logic                out_ready;
    logic [N*DATA_W-1:0] out_data;
    logic [N-1:0]        out_mask;
    logic                h_clear;
    logic [HW-1:0]       h_count;
    logic                h_overflow;
    logic                busy;

    vpu_stream_pipe #(.N(N), .ACC_W(ACC_W), .DATA_W(DATA_W), .H_DEPTH(H_DEPTH)) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
        .cfg_zero_point(cfg_zero_point), .cfg_leak(cfg_leak), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask), .bias_in(bias_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
        .h_clear(h_clear), .h_count(h_count), .h_overflow(h_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*DATA_W-1:0] d;
        logic [N-1:0]        m;
    } exp_t;

    exp_t                exp_q[$];
    logic [N*DATA_W-1:0] hq[$];
    bit                  exp_ovf = 1'b0;
    bit                  rand_rdy = 1'b0;
    int                  vectors = 0;
    int                  miscompares = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint clamp(input longint v);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (DATA_W - 1)) - 1;
        lo = -hi - 1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Expected output vector from the arithmetic rules, using the cfg currently driven.
    function automatic logic [N*DATA_W-1:0] ref_vec(input logic [1:0] mode,
                                                    input logic [N*ACC_W-1:0] dat,
                                                    input logic [N-1:0] mask,
                                                    input logic [N*DATA_W-1:0] bias,
                                                    input logic [N*DATA_W-1:0] h);
        logic [N*DATA_W-1:0] r;
        longint leak;
        r = '0;
        leak = longint'($signed(cfg_leak));
        for (int i = 0; i < N; i++) begin
            longint v;
            longint b;
            longint hv;
            v = longint'($signed(dat[i*ACC_W +: ACC_W])) * longint'(cfg_scale);
            if (cfg_shift != 0)
                v = (v + (longint'(1) <<< (cfg_shift - 1))) >>> cfg_shift;
            v  = clamp(v + longint'($signed(cfg_zero_point)));
            b  = longint'($signed(bias[i*DATA_W +: DATA_W]));
            hv = longint'($signed(h[i*DATA_W +: DATA_W]));
            if (mode == 2'b01 || mode == 2'b10) begin
                v = clamp(v + b);
                if (v < 0) v = clamp((v * leak) >>> 8);
            end else if (mode == 2'b11) begin
                if (hv < 0) v = clamp((v * leak) >>> 8);
            end
            if (!mask[i]) v = 0;
            r[i*DATA_W +: DATA_W] = DATA_W'(v);
        end
        return r;
    endfunction

    function automatic logic [N*ACC_W-1:0] rep_a(input longint a);
        logic [ACC_W-1:0] t;
        t = ACC_W'(a);
        return {N{t}};
    endfunction

    function automatic logic [N*DATA_W-1:0] rep_b(input longint b);
        logic [DATA_W-1:0] t;
        t = DATA_W'(b);
        return {N{t}};
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [1:0] mode, input logic [N*ACC_W-1:0] dat,
                        input logic [N-1:0] mask, input logic [N*DATA_W-1:0] bias);
        int guard;
        bit ok;
        logic [N*DATA_W-1:0] h;
        logic [N*DATA_W-1:0] r;
        guard = 0;
        ok = 1'b0;
        h = '0;
        cfg_mode = mode;
        in_data  = dat;
        in_mask  = mask;
        bias_in  = bias;
        in_valid = 1'b1;
        while (!ok && guard < 300) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else guard++;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: in_ready stayed 0 for mode %0d, expected 1", mode);
        end else begin
            if (mode == 2'b11) begin
                if (hq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL bwd_accept: in_ready 1 with empty H cache, expected 0");
                end else begin
                    h = hq.pop_front();
                end
            end
            r = ref_vec(mode, dat, mask, bias, h);
            exp_q.push_back('{d: r, m: mask});
            if (mode == 2'b10) begin
                if (hq.size() < H_DEPTH) hq.push_back(r);
                else exp_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        h_clear = 1'b1;
        @(posedge clk);
        #1;
        h_clear = 1'b0;
        hq.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        chk("clear_h_count", h_count, 0);
        chk("clear_h_overflow", h_overflow, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic random_beat(input bit all_modes);
        logic [1:0]          m;
        logic [N*ACC_W-1:0]  d;
        logic [N*DATA_W-1:0] b;
        cfg_scale      = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
        cfg_shift      = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 10)) : 5'($urandom);
        cfg_zero_point = 16'(int'($urandom_range(0, 400)) - 200);
        cfg_leak       = 16'($urandom);
        for (int i = 0; i < N; i++) begin
            d[i*ACC_W +: ACC_W]   = ($urandom_range(0, 3) == 0) ? ACC_W'($urandom)
                                                                : ACC_W'(int'($urandom_range(0, 8000)) - 4000);
            b[i*DATA_W +: DATA_W] = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom)
                                                                : DATA_W'(int'($urandom_range(0, 600)) - 300);
        end
        m = all_modes ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
        if (m == 2'b11 && hq.size() == 0) m = 2'b01;
        if (m == 2'b10 && hq.size() >= H_DEPTH) m = 2'b00;
        send(m, d, N'($urandom), b);
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 1) != 0);
    end

    // Monitor: pops expectations on each output handshake and checks stall hold.
    logic [N*DATA_W-1:0] held_d;
    logic [N-1:0]        held_m;
    bit                  stalled = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                vectors++;
                if (out_data !== held_d || out_mask !== held_m || out_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_hold: got %h/%b valid %b, held %h/%b", out_data, out_mask,
                             out_valid, held_d, held_m);
                end
            end
            if (out_valid && out_ready) begin
                exp_t e;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_output: got %h mask %b, expected no beat", out_data, out_mask);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.d || out_mask !== e.m) begin
                        miscompares++;
                        $display("FAIL out_beat: got %h mask %b, expected %h mask %b", out_data, out_mask,
                                 e.d, e.m);
                    end
                end
            end
            stalled = out_valid && !out_ready;
            held_d  = out_data;
            held_m  = out_mask;
        end
    end

    initial begin
        #600000;
        miscompares++;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        h_clear = 1'b0;
        cfg_mode = 2'b00;
        cfg_scale = 16'd1;
        cfg_shift = 5'd0;
        cfg_zero_point = 16'd0;
        cfg_leak = 16'h0080;
        in_data = '0;
        in_mask = '0;
        bias_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mask", out_mask, 0);
        chk("rst_h_count", h_count, 0);
        chk("rst_h_overflow", h_overflow, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Requant with rounding and zero point; three-edge latency.
        cfg_scale = 16'd3;
        cfg_shift = 5'd1;
        cfg_zero_point = 16'd5;
        send(2'b00, rep_a(1000), 4'b1011, '0);
        @(negedge clk);
        chk("lat_edge1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_edge2_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_edge3_valid", out_valid, 1);
        chk("t1_lane0", longint'($signed(out_data[DATA_W-1:0])), 1505);
        chk("t1_lane2_masked", longint'($signed(out_data[2*DATA_W +: DATA_W])), 0);
        chk("t1_mask", out_mask, 4'b1011);
        @(posedge clk);
        #1;
        drain();

        // Saturation at both rails.
        cfg_scale = 16'd1;
        cfg_shift = 5'd0;
        cfg_zero_point = 16'd0;
        send(2'b00, rep_a(longint'(32'h7FFF_FFFF)), 4'hF, '0);
        send(2'b00, rep_a(-40000), 4'hF, '0);

        // Forward: leak, bias add and bias saturation.
        cfg_leak = 16'h0080;
        send(2'b01, rep_a(-512), 4'hF, rep_b(0));
        send(2'b01, rep_a(300), 4'hF, rep_b(20));
        send(2'b01, rep_a(300), 4'hF, rep_b(32767));
        drain();

        // Ten beats under random backpressure, then a long mixed-mode run.
        rand_rdy = 1'b1;
        for (int k = 0; k < 10; k++) random_beat(1'b0);
        drain();
        for (int k = 0; k < 150; k++) random_beat(1'b1);
        drain();
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        chk("rand_h_count", h_count, hq.size());
        chk("rand_h_overflow", h_overflow, exp_ovf);
        pulse_clear();

        // H cache: overflow on the fifth push, four BWD pops, then the fifth BWD is held.
        cfg_scale = 16'd1;
        cfg_shift = 5'd0;
        cfg_zero_point = 16'd0;
        cfg_leak = 16'h0080;
        for (int k = 0; k < 5; k++) send(2'b10, rep_a(-8), 4'hF, rep_b(0));
        drain();
        chk("cache_h_count", h_count, hq.size());
        chk("cache_h_overflow", h_overflow, exp_ovf);
        for (int k = 0; k < 4; k++) send(2'b11, rep_a(100), 4'hF, rep_b(0));
        drain();
        chk("bwd_h_count", h_count, 0);
        cfg_mode = 2'b11;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bwd_empty_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pre_clear_overflow", h_overflow, 1);
        pulse_clear();

        // Reset with three beats in flight and two cached vectors.
        send(2'b10, rep_a(-8), 4'hF, rep_b(0));
        send(2'b10, rep_a(77), 4'h5, rep_b(3));
        drain();
        chk("pre_rst_h_count", h_count, 2);
        for (int k = 0; k < 3; k++) send(2'b00, rep_a(1000 + k), 4'hF, '0);
        rst = 1'b1;
        exp_q.delete();
        hq.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_h_count", h_count, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        send(2'b01, rep_a(-300), 4'hE, rep_b(10));
        drain();
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
